program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Fetch/sequence controller for the MC14500B program ROM.
//  - Owns the program counter, drives the ROM address and latches the returned instruction word.
//  - Acts on the ICU control pulses (JMP, RTN, skip, FLGF) to compute the next address.
//  - Sits between the async-read program ROM and the ICU; one instruction every 2 cycles.
// PARAMETERS
//  ADDR_WIDTH   8  ROM address / PC width; PC wraps modulo 2**ADDR_WIDTH
//  DATA_WIDTH  12  ROM word width: {opcode[3:0], operand[DATA_WIDTH-5:0]}; must be >= 5
//  STACK_DEPTH  4  return-address stack entries (>=1); used only with PROG_SEQ_CALL_STACK_EN
// PORTS
//  clk        in   1           system clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           level; leave IDLE/HALT and begin fetching
//  restart    in   1           pulse; PC<=0, stack cleared, enter FETCH (overrides all)
//  rom_addr   out  ADDR_WIDTH  address to program ROM (combinational read)
//  rom_data   in   DATA_WIDTH  instruction word from ROM
//  instr      out  DATA_WIDTH  latched instruction register (IR)
//  instr_vld  out  1           IR valid for ICU, high exactly in EXEC
//  jmp        in   1           ICU JMP pulse, sampled in EXEC
//  rtn        in   1           ICU RTN pulse, sampled in EXEC
//  skip       in   1           ICU skip-next (SKZ taken), sampled in EXEC
//  flg_f      in   1           ICU FLGF pulse = halt request, sampled in EXEC
//  halted     out  1           high in HALT
//  err        out  1           sticky; stack over/underflow or jmp&rtn together
//  pc         out  ADDR_WIDTH  current program counter
//  sp         out  $clog2(STACK_DEPTH+1)  stack occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=0, sp=0, instr=0, instr_vld=0, halted=0, err=0.
//  rom_addr = pc (combinational); IR loads rom_data on the FETCH->EXEC edge only.
//  FSM:
//   IDLE  -> FETCH when start=1.
//   FETCH -> EXEC (1 cycle; IR<=rom_data).
//   EXEC  -> FETCH; instr_vld=1; ICU inputs sampled this cycle; pc updated at its end.
//   HALT  -> FETCH when start=1; pc keeps its value; err stays as is.
//  EXEC next-pc priority, highest first:
//   1. jmp&rtn both high: err<=1, ->HALT, pc unchanged.
//   2. flg_f: ->HALT, pc<=pc+1 (resume continues after the halt).
//   3. jmp: push pc+1 if stack enabled; pc<=operand[ADDR_WIDTH-1:0], zero-extended if narrower.
//      - push when sp==STACK_DEPTH: err<=1, ->HALT, pc unchanged, stack unchanged.
//   4. rtn: pop; pc<=popped address.
//      - pop when sp==0: err<=1, ->HALT, pc unchanged.
//   5. skip: pc<=pc+2 (mod 2**ADDR_WIDTH).
//   6. else pc<=pc+1.
//  Ignored while not in EXEC: jmp, rtn, skip, flg_f.
//  Wrap-around: pc=2**ADDR_WIDTH-1 +1 -> 0; +2 -> 1; no error.
//  Stack: LIFO; sp increments on push, decrements on pop; the pushed value is the return address.
//  restart: pc<=0, sp<=0, err<=0, instr_vld<=0, ->FETCH. Effective in any state, next edge.
//  Reset mid-instruction: all state is cleared immediately; no partial pc update survives.
// CONFIGURATION
//  PROG_SEQ_CALL_STACK_EN defined:
//   - jmp pushes and rtn pops as above; sp reflects occupancy.
//  PROG_SEQ_CALL_STACK_EN undefined:
//   - no stack storage; jmp is a plain jump with no push.
//   - rtn is treated as priority 6 (pc+1) and never sets err.
//   - sp tied 0; STACK_DEPTH ignored.
// TESTING
//  T1 reset, start=1, ROM linear NOPs: rom_addr 0,0,1,1,2,2..; instr_vld on every 2nd cycle.
//  T2 EXEC at pc=0x10 with skip=1 -> next fetch at 0x12; at pc=0xFF with skip -> 0x01.
//  T3 (stack on) jmp at 0x05, operand 0x40 -> fetch 0x40, sp=1; rtn at 0x42 -> fetch 0x06, sp=0.
//  T4 (stack on, DEPTH=4) 5 nested jmps -> err=1, halted=1, pc=5th jmp addr; rtn with sp=0 -> err.
//  T5 flg_f at pc=0x20 -> halted=1, pc=0x21; start -> fetch 0x21; jmp&rtn together -> err, HALT.
//  T6 rst_n low during EXEC of jmp -> pc=0, sp=0, IDLE; restart in HALT -> fetch 0x00, err=0.

Source files
------------

// File: rtl/program_sequencer.sv
// Fetch/sequence controller for the MC14500B program ROM: owns the PC, latches the IR, reacts to ICU pulses.
// Optional return-address stack enabled by defining PROG_SEQ_CALL_STACK_EN.
module program_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             restart,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_data,
  output logic [DATA_WIDTH-1:0]            instr,
  output logic                             instr_vld,
  input  logic                             jmp,
  input  logic                             rtn,
  input  logic                             skip,
  input  logic                             flg_f,
  output logic                             halted,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   jmp_target;
  logic [DATA_WIDTH-1:0]   instr_reg;
  logic                    err_reg, err_next;

  assign pc_inc = pc_reg + ADDR_WIDTH'(1);
  // Operand is truncated or zero-extended to the PC width by the sized cast.
  assign jmp_target = ADDR_WIDTH'(instr_reg[DATA_WIDTH-5:0]);

`ifdef PROG_SEQ_CALL_STACK_EN
  logic [SP_W-1:0]        sp_reg;
  logic                   push_en, pop_en;
  logic [ADDR_WIDTH-1:0]  stack_reg [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0]  stack_top;
  logic [STACK_DEPTH-1:0] wr_en, rd_sel;

  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack_sel
      assign wr_en[gi]  = push_en && (sp_reg == SP_W'(gi));
      assign rd_sel[gi] = (sp_reg == SP_W'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (wr_en[i]) stack_reg[i] <= pc_inc;
      end
    end
  end

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (rd_sel[i]) stack_top = stack_top | stack_reg[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sp_reg <= '0;
    else if (restart) sp_reg <= '0;
    else if (push_en) sp_reg <= sp_reg + SP_W'(1);
    else if (pop_en)  sp_reg <= sp_reg - SP_W'(1);
  end

  assign sp = sp_reg;
`else
  assign sp = '0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    err_next   = err_reg;
`ifdef PROG_SEQ_CALL_STACK_EN
    push_en    = 1'b0;
    pop_en     = 1'b0;
`endif
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        if (jmp && rtn) begin
          err_next   = 1'b1;
          state_next = S_HALT;
        end else if (flg_f) begin
          state_next = S_HALT;
          pc_next    = pc_inc;
        end else if (jmp) begin
`ifdef PROG_SEQ_CALL_STACK_EN
          if (sp_reg == SP_W'(STACK_DEPTH)) begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end else begin
            push_en = 1'b1;
            pc_next = jmp_target;
          end
`else
          pc_next = jmp_target;
`endif
        end
`ifdef PROG_SEQ_CALL_STACK_EN
        else if (rtn) begin
          if (sp_reg == '0) begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end else begin
            pop_en  = 1'b1;
            pc_next = stack_top;
          end
        end
`endif
        else if (skip) begin
          pc_next = pc_reg + ADDR_WIDTH'(2);
        end else begin
          pc_next = pc_inc;
        end
      end
      S_HALT:  if (start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
    // restart beats every other condition, including a stack operation in EXEC.
    if (restart) begin
      state_next = S_FETCH;
      pc_next    = '0;
      err_next   = 1'b0;
`ifdef PROG_SEQ_CALL_STACK_EN
      push_en    = 1'b0;
      pop_en     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      err_reg   <= 1'b0;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      err_reg   <= err_next;
      if (state_reg == S_FETCH && state_next == S_EXEC) instr_reg <= rom_data;
    end
  end

  assign rom_addr  = pc_reg;
  assign pc        = pc_reg;
  assign instr     = instr_reg;
  assign instr_vld = (state_reg == S_EXEC);
  assign halted    = (state_reg == S_HALT);
  assign err       = err_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected EXEC addresses are queued as stimulus is driven.
// Stack-dependent expectations follow PROG_SEQ_CALL_STACK_EN.
`timescale 1ns/1ps
module tb_program_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 12;
  localparam int SD  = 4;
  localparam int SPW = $clog2(SD + 1);
`ifdef PROG_SEQ_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, restart = 1'b0;
  logic           jmp = 1'b0, rtn = 1'b0, skip = 1'b0, flg_f = 1'b0;
  logic [AW-1:0]  rom_addr, pc;
  logic [DW-1:0]  rom_data, instr;
  logic           instr_vld, halted, err;
  logic [SPW-1:0] sp;

  logic [DW-1:0]  rom_mem [256];
  logic [AW-1:0]  exp_q [$];
  int             total = 0;
  int             passed = 0;

  assign rom_data = rom_mem[rom_addr];

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .restart(restart),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .instr_vld(instr_vld),
    .jmp(jmp), .rtn(rtn), .skip(skip), .flg_f(flg_f),
    .halted(halted), .err(err), .pc(pc), .sp(sp)
  );

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i * 13 + 7);
  endtask

  task automatic start_clean();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; restart = 1'b0;
    jmp = 1'b0; rtn = 1'b0; skip = 1'b0; flg_f = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
  endtask

  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (instr_vld === 1'b1) ok = 1'b1;
    end
  endtask

  // Waits for the next EXEC and pops the address the scoreboard expects there.
  task automatic next_exec(output bit ok, output logic [AW-1:0] want);
    wait_exec(ok);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
  endtask

  task automatic drive(input bit j, input bit r, input bit s, input bit f);
    jmp = j; rtn = r; skip = s; flg_f = f;
    @(negedge clk);
    jmp = 1'b0; rtn = 1'b0; skip = 1'b0; flg_f = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (pc !== 8'h00 || rom_addr !== 8'h00) $display("FAIL reset_pc pc=%h rom_addr=%h want 00", pc, rom_addr); else begin passed++; $display("ok   reset_pc"); end
    total++; if (sp !== '0) $display("FAIL reset_sp got %0d want 0", sp); else begin passed++; $display("ok   reset_sp"); end
    total++; if (instr !== 12'h000 || instr_vld !== 1'b0) $display("FAIL reset_ir instr=%h vld=%b want 000/0", instr, instr_vld); else begin passed++; $display("ok   reset_ir"); end
    total++; if (halted !== 1'b0 || err !== 1'b0) $display("FAIL reset_flags halted=%b err=%b want 0/0", halted, err); else begin passed++; $display("ok   reset_flags"); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (instr_vld !== 1'b0 || rom_addr !== 8'h00) $display("FAIL idle_hold vld=%b rom_addr=%h want 0/00", instr_vld, rom_addr); else begin passed++; $display("ok   idle_hold"); end
  endtask

  task automatic test_linear();
    bit ok; logic [AW-1:0] want;
    fill_rom();
    start_clean();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(AW'(k));
      next_exec(ok, want);
      total++; if (!ok || pc !== want || instr !== rom_mem[want]) $display("FAIL lin_exec ok=%b pc=%h instr=%h want %h/%h", ok, pc, instr, want, rom_mem[want]); else begin passed++; $display("ok   lin_exec pc=%h", pc); end
      drive(0, 0, 0, 0);
      total++; if (instr_vld !== 1'b0 || rom_addr !== want + 8'h01) $display("FAIL lin_fetch vld=%b rom_addr=%h want 0/%h", instr_vld, rom_addr, want + 8'h01); else begin passed++; $display("ok   lin_fetch addr=%h", rom_addr); end
    end
  endtask

  task automatic test_skip();
    bit ok; logic [AW-1:0] want;
    fill_rom();
    rom_mem[8'h00] = 12'h010;
    rom_mem[8'h12] = 12'h0FF;
    start_clean();
    exp_q.push_back(8'h00); next_exec(ok, want);
    exp_q.push_back(8'h10); drive(1, 0, 0, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL skip_at10 ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   skip_at10"); end
    exp_q.push_back(8'h12); drive(0, 0, 1, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want || instr !== 12'h0FF) $display("FAIL skip_to12 ok=%b pc=%h instr=%h want %h/0ff", ok, pc, instr, want); else begin passed++; $display("ok   skip_to12"); end
    exp_q.push_back(8'hFF); drive(1, 0, 0, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL skip_atff ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   skip_atff"); end
    exp_q.push_back(8'h01); drive(0, 0, 1, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want || err !== 1'b0) $display("FAIL skip_wrap ok=%b pc=%h err=%b want %h/0", ok, pc, err, want); else begin passed++; $display("ok   skip_wrap"); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_stack();
    bit ok; logic [AW-1:0] want;
    fill_rom();
    rom_mem[8'h05] = 12'h040;
    start_clean();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(AW'(k)); next_exec(ok, want); drive(0, 0, 0, 0);
    end
    exp_q.push_back(8'h05); next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL call_site ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   call_site"); end
    exp_q.push_back(8'h40); drive(1, 0, 0, 0);
    total++; if (sp !== SPW'(STACK_EN ? 1 : 0)) $display("FAIL call_sp got %0d want %0d", sp, STACK_EN ? 1 : 0); else begin passed++; $display("ok   call_sp"); end
    next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL call_target ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   call_target"); end
    exp_q.push_back(8'h41); drive(0, 0, 0, 0);
    next_exec(ok, want);
    exp_q.push_back(8'h42); drive(0, 0, 0, 0);
    next_exec(ok, want);
    exp_q.push_back(STACK_EN ? 8'h06 : 8'h43); drive(0, 1, 0, 0);
    total++; if (sp !== '0 || err !== 1'b0) $display("FAIL rtn_sp sp=%0d err=%b want 0/0", sp, err); else begin passed++; $display("ok   rtn_sp"); end
    next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL rtn_target ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   rtn_target pc=%h", pc); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    bit ok; logic [AW-1:0] want;
    logic [AW-1:0] site [5];
    site[0] = 8'h00; site[1] = 8'h10; site[2] = 8'h20; site[3] = 8'h30; site[4] = 8'h40;
    fill_rom();
    for (int k = 0; k < 5; k++) rom_mem[site[k]] = DW'(site[k] + 8'h10);
    start_clean();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(site[k]); next_exec(ok, want);
      total++; if (!ok || pc !== want) $display("FAIL nest_exec ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   nest_exec pc=%h", pc); end
      drive(1, 0, 0, 0);
    end
    exp_q.push_back(8'h40); next_exec(ok, want);
    start = 1'b0;
`ifdef PROG_SEQ_CALL_STACK_EN
    drive(1, 0, 0, 0);
    total++; if (err !== 1'b1 || halted !== 1'b1 || pc !== 8'h40 || sp !== 3'd4) $display("FAIL overflow err=%b halted=%b pc=%h sp=%0d want 1/1/40/4", err, halted, pc, sp); else begin passed++; $display("ok   overflow"); end
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    total++; if (err !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'h00 || sp !== '0) $display("FAIL restart err=%b halted=%b rom_addr=%h sp=%0d want 0/0/00/0", err, halted, rom_addr, sp); else begin passed++; $display("ok   restart"); end
    exp_q.push_back(8'h00); next_exec(ok, want);
    drive(0, 1, 0, 0);
    total++; if (err !== 1'b1 || halted !== 1'b1 || pc !== 8'h00) $display("FAIL underflow err=%b halted=%b pc=%h want 1/1/00", err, halted, pc); else begin passed++; $display("ok   underflow"); end
`else
    exp_q.push_back(8'h50); drive(1, 0, 0, 0);
    start = 1'b1;
    next_exec(ok, want);
    total++; if (!ok || pc !== want || err !== 1'b0 || sp !== '0) $display("FAIL plain_jmp ok=%b pc=%h err=%b sp=%0d want %h/0/0", ok, pc, err, sp, want); else begin passed++; $display("ok   plain_jmp"); end
    exp_q.push_back(8'h51); drive(0, 1, 0, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want || err !== 1'b0) $display("FAIL rtn_as_nop ok=%b pc=%h err=%b want %h/0", ok, pc, err, want); else begin passed++; $display("ok   rtn_as_nop"); end
    drive(0, 0, 0, 0);
`endif
    start = 1'b1;
  endtask

  task automatic test_halt();
    bit ok; logic [AW-1:0] want;
    fill_rom();
    rom_mem[8'h00] = 12'h020;
    start_clean();
    exp_q.push_back(8'h00); next_exec(ok, want);
    exp_q.push_back(8'h20); drive(1, 0, 0, 0);
    next_exec(ok, want);
    start = 1'b0;
    drive(0, 0, 0, 1);
    total++; if (halted !== 1'b1 || pc !== 8'h21 || err !== 1'b0) $display("FAIL flgf_halt halted=%b pc=%h err=%b want 1/21/0", halted, pc, err); else begin passed++; $display("ok   flgf_halt"); end
    drive(1, 0, 1, 0);
    total++; if (halted !== 1'b1 || pc !== 8'h21 || instr_vld !== 1'b0) $display("FAIL halt_ignore halted=%b pc=%h vld=%b want 1/21/0", halted, pc, instr_vld); else begin passed++; $display("ok   halt_ignore"); end
    start = 1'b1;
    exp_q.push_back(8'h21); next_exec(ok, want);
    total++; if (!ok || pc !== want || instr !== rom_mem[want]) $display("FAIL resume ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   resume"); end
    start = 1'b0;
    drive(1, 1, 0, 0);
    total++; if (err !== 1'b1 || halted !== 1'b1 || pc !== 8'h21 || sp !== SPW'(STACK_EN ? 1 : 0)) $display("FAIL jmp_rtn err=%b halted=%b pc=%h sp=%0d want 1/1/21/%0d", err, halted, pc, sp, STACK_EN ? 1 : 0); else begin passed++; $display("ok   jmp_rtn"); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [AW-1:0] want;
    fill_rom();
    rom_mem[8'h00] = 12'h003;
    rom_mem[8'h03] = 12'h040;
    start_clean();
    exp_q.push_back(8'h00); next_exec(ok, want);
    exp_q.push_back(8'h03); drive(1, 0, 0, 0);
    next_exec(ok, want);
    total++; if (!ok || pc !== want) $display("FAIL mid_exec ok=%b pc=%h want %h", ok, pc, want); else begin passed++; $display("ok   mid_exec"); end
    jmp = 1'b1; rst_n = 1'b0; start = 1'b0;
    #1;
    total++; if (pc !== 8'h00 || sp !== '0 || instr_vld !== 1'b0 || instr !== 12'h000) $display("FAIL async_rst pc=%h sp=%0d vld=%b instr=%h want 00/0/0/000", pc, sp, instr_vld, instr); else begin passed++; $display("ok   async_rst"); end
    @(negedge clk);
    jmp = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (instr_vld !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'h00) $display("FAIL rst_idle vld=%b halted=%b rom_addr=%h want 0/0/00", instr_vld, halted, rom_addr); else begin passed++; $display("ok   rst_idle"); end
    start = 1'b1;
    exp_q.push_back(8'h00); next_exec(ok, want);
    start = 1'b0;
    drive(1, 1, 0, 0);
    total++; if (err !== 1'b1 || halted !== 1'b1) $display("FAIL pre_restart err=%b halted=%b want 1/1", err, halted); else begin passed++; $display("ok   pre_restart"); end
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    total++; if (err !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'h00) $display("FAIL halt_restart err=%b halted=%b rom_addr=%h want 0/0/00", err, halted, rom_addr); else begin passed++; $display("ok   halt_restart"); end
    exp_q.push_back(8'h00); next_exec(ok, want);
    total++; if (!ok || pc !== want || instr !== 12'h003) $display("FAIL restart_fetch ok=%b pc=%h instr=%h want %h/003", ok, pc, instr, want); else begin passed++; $display("ok   restart_fetch"); end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_skip();
    test_stack();
    test_overflow();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
